// File: rtl/mag_window_stats.sv
// mag_window_stats: reduces the 8-bit magnitude stream over windows of 2^WIN_LOG2
// accepted samples, reporting the truncated mean and the peak per window, and runs
// a hysteretic alarm FSM on each window mean.
// Optional feature macro: MAG_STATS_PEAK_EN (defined -> peak tracking present,
// undefined -> peak_out tied to 0).
module mag_window_stats #(
    parameter int unsigned WIN_LOG2  = 3,
    parameter logic [7:0]  THRESH_HI = 8'd200,
    parameter logic [7:0]  THRESH_LO = 8'd150,
    parameter int unsigned ALARM_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    input  logic [7:0] in_mag,
    output logic       out_valid,
    output logic [7:0] mean_out,
    output logic [7:0] peak_out,
    output logic       alarm,
    output logic [1:0] fsm_state
);

    localparam int unsigned AccW = 8 + WIN_LOG2;

    localparam logic [1:0] StClear  = 2'd0;
    localparam logic [1:0] StArming = 2'd1;
    localparam logic [1:0] StAlarm  = 2'd2;

    localparam logic [3:0]          AlarmCnt = ALARM_CNT[3:0];
    localparam logic [WIN_LOG2-1:0] CntLast  = '1;
    localparam logic [WIN_LOG2-1:0] CntOne   = WIN_LOG2'(1);

    logic [AccW-1:0]     acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [1:0]          state_q, state_d;
    logic [3:0]          arm_cnt_q, arm_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          mean_q, mean_d;
    logic                alarm_q, alarm_d;

    logic            accept;
    logic            close;
    logic [AccW-1:0] sum;
    logic [7:0]      win_mean;

    assign accept   = ena & in_valid;
    assign close    = accept && (cnt_q == CntLast);
    // Accumulator is wide enough for a full window of 255s, so this cannot wrap.
    assign sum      = acc_q + AccW'(in_mag);
    assign win_mean = sum[AccW-1:WIN_LOG2];

    // Accumulate accepted samples; on the closing sample publish the mean and restart.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mean_d      = mean_q;
        out_valid_d = 1'b0;
        if (accept) begin
            if (close) begin
                acc_d       = '0;
                cnt_d       = '0;
                mean_d      = win_mean;
                out_valid_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    // Alarm FSM: steps only at window close, using the freshly computed mean.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        if (close) begin
            case (state_q)
                StClear: begin
                    if (win_mean >= THRESH_HI) begin
                        if (ALARM_CNT == 1) begin
                            state_d = StAlarm;
                        end else begin
                            state_d   = StArming;
                            arm_cnt_d = 4'd1;
                        end
                    end
                end
                StArming: begin
                    if (win_mean >= THRESH_HI) begin
                        arm_cnt_d = arm_cnt_q + 4'd1;
                        if (arm_cnt_d == AlarmCnt) begin
                            state_d = StAlarm;
                        end
                    end else begin
                        state_d   = StClear;
                        arm_cnt_d = '0;
                    end
                end
                StAlarm: begin
                    // Hysteresis: only a mean below the low threshold releases.
                    if (win_mean < THRESH_LO) begin
                        state_d   = StClear;
                        arm_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = StClear;
                    arm_cnt_d = '0;
                end
            endcase
        end
        alarm_d = (state_d == StAlarm);
    end

    // State registers; out_valid_d is 0 whenever no window closes, so the pulse
    // drops even while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= StClear;
            arm_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            mean_q      <= '0;
            alarm_q     <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            out_valid_q <= out_valid_d;
            mean_q      <= mean_d;
            alarm_q     <= alarm_d;
        end
    end

`ifdef MAG_STATS_PEAK_EN
    logic [7:0] peak_q, peak_d;
    logic [7:0] peak_out_q, peak_out_d;
    logic [7:0] peak_max;

    assign peak_max = (in_mag > peak_q) ? in_mag : peak_q;

    // Running maximum of the window; published and cleared on the closing sample.
    always_comb begin
        peak_d     = peak_q;
        peak_out_d = peak_out_q;
        if (accept) begin
            if (close) begin
                peak_d     = '0;
                peak_out_d = peak_max;
            end else begin
                peak_d = peak_max;
            end
        end
    end

    // Peak registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q     <= '0;
            peak_out_q <= '0;
        end else begin
            peak_q     <= peak_d;
            peak_out_q <= peak_out_d;
        end
    end

    assign peak_out = peak_out_q;
`else
    assign peak_out = 8'd0;
`endif

    assign out_valid = out_valid_q;
    assign mean_out  = mean_q;
    assign alarm     = alarm_q;
    assign fsm_state = state_q;

endmodule

// File: doc/mag_window_stats.md
# mag_window_stats

Downstream stage of the magnitude block: consumes the 8-bit magnitude stream and reduces it over fixed windows of 2^WIN_LOG2 accepted samples. Per window it reports the truncated mean and the peak. A hysteretic alarm FSM is evaluated on each window's mean. Results feed the top-level output mux and the alarm pin.

## Interface
- WIN_LOG2, 3: window length is 2^WIN_LOG2 samples; legal range 1..6.
- THRESH_HI, 8'd200: alarm arming threshold (mean >= THRESH_HI).
- THRESH_LO, 8'd150: alarm release threshold (mean < THRESH_LO); must be <= THRESH_HI.
- ALARM_CNT, 2: consecutive windows at or above THRESH_HI needed to raise the alarm; legal range 1..15.
- clk  input  1  Single clock; all state changes on the rising edge.
- rst_n  input  1  Reset: asynchronous, active-low.
- ena  input  1  Block enable; low freezes all state.
- in_valid  input  1  A magnitude sample is present this cycle.
- in_mag  input  8  Magnitude sample, unsigned.
- out_valid  output  1  One-cycle pulse: mean_out and peak_out are new.
- mean_out  output  8  Truncated window mean; holds between pulses.
- peak_out  output  8  Window maximum; holds between pulses.
- alarm  output  1  Alarm level.
- fsm_state  output  2  Alarm FSM state, for debug: 0 CLEAR, 1 ARMING, 2 ALARM.

## Operation
- Sample acceptance: a sample is accepted on an edge where ena=1 and in_valid=1. There is no backpressure; every such sample is taken.
- Accumulator: unsigned, width 8+WIN_LOG2. It cannot overflow, because 2^WIN_LOG2 * 255 fits in that width.
- Sample counter: width WIN_LOG2; wraps from 2^WIN_LOG2-1 to 0.
- Window close: the accepted sample that arrives with the counter at 2^WIN_LOG2-1 closes the window. On that same edge:
  - mean_out <= (acc + in_mag) >> WIN_LOG2, truncated.
  - peak_out <= max(peak, in_mag).
  - out_valid <= 1.
  - acc, peak and counter are cleared to 0.
  - The alarm FSM steps using the new mean.
- out_valid drops on the next edge unconditionally, including when ena=0. It is never high for two consecutive cycles.
- Alarm FSM: state changes only at window close. arm_cnt is 4 bits.
  - CLEAR: if mean >= THRESH_HI: go to ALARM when ALARM_CNT==1, else go to ARMING with arm_cnt=1. Otherwise stay in CLEAR.
  - ARMING: if mean >= THRESH_HI: arm_cnt increments, and the FSM goes to ALARM when arm_cnt+1 == ALARM_CNT. If mean < THRESH_HI: go to CLEAR and set arm_cnt=0.
  - ALARM: if mean < THRESH_LO: go to CLEAR and set arm_cnt=0. Otherwise stay in ALARM; hysteresis holds for THRESH_LO <= mean < THRESH_HI.
  - alarm = (state==ALARM), registered. It changes on the same edge that raises out_valid.
- ena=0: samples are ignored. acc, peak, counter, FSM and all output values hold. Only the out_valid clear still happens.

## Timing
- Reset (asynchronous): out_valid=0, mean_out=0, peak_out=0, alarm=0, fsm_state=CLEAR. acc, peak, counter and arm_cnt are all 0.
- Reset in the middle of a window discards the partial window. The first window after reset needs a full 2^WIN_LOG2 new samples.
- Latency: mean_out, peak_out, alarm and out_valid are valid in the cycle immediately after the edge that accepted the closing sample.
- Window throughput: one window per 2^WIN_LOG2 accepted samples. Back-to-back windows are supported with in_valid held high.
- Simultaneous close and accept: when out_valid is high, a sample accepted in that cycle counts as sample 0 of the next window.
- Gaps in in_valid stretch a window; they do not end it.

## Configuration
- MAG_STATS_PEAK_EN:
  - Defined: peak tracking register and comparator are present, and peak_out behaves as described above.
  - Undefined: peak logic is removed and peak_out is tied to 8'd0. Mean and alarm behaviour are unchanged.

## Test plan
- Defaults, 8 samples of 100 -> one out_valid pulse; mean_out=100, peak_out=100, alarm=0, fsm_state=CLEAR.
- Samples 10,20,...,80 -> mean_out=45 (360>>3), peak_out=80; next window of 8 zeros -> mean_out=0, peak_out=0.
- Window sequence with means 210, 210, 170, 140:
  - fsm_state goes ARMING, then ALARM with alarm=1 at the 2nd pulse.
  - alarm stays 1 at 170.
  - alarm drops to 0 and state goes CLEAR at 140.
- Window means 210, 160, 210 -> ARMING, CLEAR, ARMING; alarm never asserts.
- 8 samples of 255 interleaved with in_valid gaps and ena=0 for 5 cycles mid-window:
  - Exactly one pulse after the 8th accepted sample, with mean_out=255 and peak_out=255.
  - Outputs hold while ena=0.
  - out_valid is a single-cycle pulse.
- rst_n asserted after 5 samples of 250 -> outputs 0 immediately; the next 8 samples of 50 yield mean_out=50 and peak_out=50. Repeat the suite with MAG_STATS_PEAK_EN undefined -> peak_out is always 0.
